// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES decryption round-key path.
//   klen_t        : key length select encoding (128/192/256/invalid)
//   rkbuf_state_t : round-key reversal buffer states
//   nkeys()       : number of round keys (Nr+1) for a key length
package aes_dec_pkg;

    localparam int unsigned KW         = 128;
    localparam int unsigned NUM_RK_MAX = 15;

    typedef enum logic [1:0] {
        K128 = 2'b00,
        K192 = 2'b01,
        K256 = 2'b10,
        KINV = 2'b11
    } klen_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        LOAD  = 2'b01,
        READY = 2'b10
    } rkbuf_state_t;

    // Round keys in a schedule; the invalid code maps to the largest depth.
    function automatic logic [3:0] nkeys(input klen_t k);
        case (k)
            K128:    return 4'd11;
            K192:    return 4'd13;
            default: return 4'd15;
        endcase
    endfunction

endpackage

// File: rtl/rk_store.sv
// Round-key storage: synchronous write, asynchronous read register array.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data (combinational from raddr)
module rk_store #(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 15,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // No reset: contents are only meaningful once a full schedule is written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rkey_rev_buf.sv
// Round-key reversal buffer. Captures a forward key schedule rk[0]..rk[Nr]
// from the key expander and replays it as rk[Nr]..rk[0] to the decrypt
// engine, repeating per block until a new key is loaded. A new_key arriving
// mid-block is deferred until the block boundary.
//   clk, rst   : clock, synchronous active-high reset
//   new_key    : request a new schedule load (klen_sel sampled with it)
//   klen_sel   : key length select
//   ek/ek_vld/ek_rdy : forward-order round key input handshake
//   rkey/rkey_vld    : reverse-order round key output, full schedule present
//   next_rkey  : decrypt engine consumes the current rkey
//   klen_out   : key length of the stored schedule
//   klen_err   : sticky, last applied new_key carried an invalid length
//   load_pend  : a new_key is waiting for the block boundary
module rkey_rev_buf #(
    parameter int unsigned KW         = aes_dec_pkg::KW,
    parameter int unsigned NUM_RK_MAX = aes_dec_pkg::NUM_RK_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          new_key,
    input  logic [1:0]    klen_sel,
    input  logic [KW-1:0] ek,
    input  logic          ek_vld,
    output logic          ek_rdy,
    output logic [KW-1:0] rkey,
    output logic          rkey_vld,
    input  logic          next_rkey,
    output logic [1:0]    klen_out,
    output logic          klen_err,
    output logic          load_pend
);

    import aes_dec_pkg::*;

    localparam int unsigned PTR_W = $clog2(NUM_RK_MAX);

    rkbuf_state_t     state,     state_d;
    logic [PTR_W-1:0] wr_cnt,    wr_cnt_d;
    logic [PTR_W-1:0] rd_ptr,    rd_ptr_d;
    klen_t            klen,      klen_d;
    klen_t            pend_klen, pend_klen_d;
    logic             klen_err_d;
    logic             load_pend_d;
    logic             ek_rdy_d;
    logic             rkey_vld_d;

    logic             wr_en_c;
    logic             start_c;
    klen_t            start_klen_c;
    logic [PTR_W-1:0] last_c;
    logic             at_bound_c;
    logic             wrap_c;

    // Index of rk[Nr] for the stored schedule; also the block boundary.
    assign last_c     = PTR_W'(nkeys(klen)) - PTR_W'(1);
    assign at_bound_c = (rd_ptr == last_c);
    assign wrap_c     = next_rkey && (rd_ptr == '0);

    rk_store #(
        .W     (KW),
        .DEPTH (NUM_RK_MAX),
        .AW    (PTR_W)
    ) u_store (
        .clk   (clk),
        .we    (wr_en_c),
        .waddr (wr_cnt),
        .wdata (ek),
        .raddr (rd_ptr),
        .rdata (rkey)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            klen      <= K128;
            pend_klen <= K128;
            klen_err  <= 1'b0;
            load_pend <= 1'b0;
            ek_rdy    <= 1'b0;
            rkey_vld  <= 1'b0;
        end else begin
            state     <= state_d;
            wr_cnt    <= wr_cnt_d;
            rd_ptr    <= rd_ptr_d;
            klen      <= klen_d;
            pend_klen <= pend_klen_d;
            klen_err  <= klen_err_d;
            load_pend <= load_pend_d;
            ek_rdy    <= ek_rdy_d;
            rkey_vld  <= rkey_vld_d;
        end
    end

    assign klen_out = klen;

    // Next-state logic; all load starts funnel through start_c/start_klen_c.
    always_comb begin
        state_d      = state;
        wr_cnt_d     = wr_cnt;
        rd_ptr_d     = rd_ptr;
        klen_d       = klen;
        pend_klen_d  = pend_klen;
        klen_err_d   = klen_err;
        load_pend_d  = load_pend;
        wr_en_c      = 1'b0;
        start_c      = 1'b0;
        start_klen_c = K128;

        case (state)
            EMPTY: begin
                if (new_key) begin
                    start_c      = 1'b1;
                    start_klen_c = klen_t'(klen_sel);
                end
            end
            LOAD: begin
                if (new_key) begin
                    start_c      = 1'b1;
                    start_klen_c = klen_t'(klen_sel);
                end else if (ek_vld && ek_rdy) begin
                    wr_en_c = 1'b1;
                    if (wr_cnt == last_c) begin
                        state_d  = READY;
                        rd_ptr_d = last_c;
                    end else begin
                        wr_cnt_d = wr_cnt + PTR_W'(1);
                    end
                end
            end
            READY: begin
                if (next_rkey) begin
                    rd_ptr_d = (rd_ptr == '0) ? last_c : rd_ptr - PTR_W'(1);
                end
                if (new_key && at_bound_c && !next_rkey) begin
                    start_c      = 1'b1;
                    start_klen_c = klen_t'(klen_sel);
                end else if (wrap_c && (new_key || load_pend)) begin
                    // A new_key on the wrapping pop is the most recent request.
                    start_c      = 1'b1;
                    start_klen_c = new_key ? klen_t'(klen_sel) : pend_klen;
                end else if (new_key) begin
                    load_pend_d = 1'b1;
                    pend_klen_d = klen_t'(klen_sel);
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        if (start_c) begin
            load_pend_d = 1'b0;
            wr_cnt_d    = '0;
            if (start_klen_c == KINV) begin
                klen_err_d = 1'b1;
                state_d    = EMPTY;
            end else begin
                klen_err_d = 1'b0;
                klen_d     = start_klen_c;
                state_d    = LOAD;
            end
        end

        ek_rdy_d   = (state_d == LOAD);
        rkey_vld_d = (state_d == READY);
    end

endmodule

// File: tb/tb_rkey_rev_buf.sv
// Scoreboard bench for rkey_rev_buf: expected replay order is queued when a
// schedule is loaded; a negedge monitor pops and compares on every consume.
module tb_rkey_rev_buf;

    logic         clk = 1'b0;
    logic         rst;
    logic         new_key;
    logic [1:0]   klen_sel;
    logic [127:0] ek;
    logic         ek_vld;
    logic         ek_rdy;
    logic [127:0] rkey;
    logic         rkey_vld;
    logic         next_rkey;
    logic [1:0]   klen_out;
    logic         klen_err;
    logic         load_pend;

    int tests = 0;
    int fails = 0;
    logic [127:0] exp_q[$];

    always #5 clk = ~clk;

    rkey_rev_buf dut (
        .clk       (clk),
        .rst       (rst),
        .new_key   (new_key),
        .klen_sel  (klen_sel),
        .ek        (ek),
        .ek_vld    (ek_vld),
        .ek_rdy    (ek_rdy),
        .rkey      (rkey),
        .rkey_vld  (rkey_vld),
        .next_rkey (next_rkey),
        .klen_out  (klen_out),
        .klen_err  (klen_err),
        .load_pend (load_pend)
    );

    function automatic logic [127:0] mk(input int tag, input int idx);
        logic [127:0] v;
        v          = '0;
        v[127:120] = 8'(tag);
        v[71:64]   = 8'(tag ^ idx);
        v[7:0]     = 8'(idx);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Queue 'count' expected pops starting at index 'start', descending with wrap.
    task automatic push_rev(input int tag, input int n, input int start, input int count);
        int idx;
        idx = start;
        for (int k = 0; k < count; k++) begin
            exp_q.push_back(mk(tag, idx));
            idx = (idx == 0) ? n - 1 : idx - 1;
        end
    endtask

    task automatic load(input int tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk("ek_rdy_load", 128'(ek_rdy), 128'(1));
            ek_vld = 1'b1;
            ek     = mk(tag, i);
            tick();
        end
        ek_vld = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && rkey_vld && next_rkey) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_underflow: got %0h expected none", rkey);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (rkey !== e) begin
                    fails++;
                    $display("FAIL rkey_pop: got %0h expected %0h", rkey, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; new_key = 1'b0; klen_sel = 2'b00; ek = '0; ek_vld = 1'b0; next_rkey = 1'b0;
        #1;
        tick(); tick();
        chk("rst_ek_rdy",    128'(ek_rdy),    128'(0));
        chk("rst_rkey_vld",  128'(rkey_vld),  128'(0));
        chk("rst_klen_out",  128'(klen_out),  128'(0));
        chk("rst_klen_err",  128'(klen_err),  128'(0));
        chk("rst_load_pend", 128'(load_pend), 128'(0));
        rst = 1'b0;
        tick();

        // 128-bit load with a stray next_rkey held through EMPTY and LOAD.
        push_rev(1, 11, 10, 22);
        new_key = 1'b1; klen_sel = 2'b00; next_rkey = 1'b1;
        tick();
        new_key = 1'b0;
        chk("t1_rkey_vld_load", 128'(rkey_vld), 128'(0));
        load(1, 11);
        chk("t1_rkey_vld_rise", 128'(rkey_vld), 128'(1));
        chk("t1_first_rkey",    rkey,           mk(1, 10));
        chk("t1_klen_out",      128'(klen_out), 128'(0));
        repeat (22) tick();
        next_rkey = 1'b0;
        chk("t1_wrap_rkey", rkey, mk(1, 10));

        // 256-bit load at the boundary with ek_vld toggling.
        new_key = 1'b1; klen_sel = 2'b10;
        tick();
        new_key = 1'b0;
        chk("t2_rkey_vld_drop", 128'(rkey_vld), 128'(0));
        chk("t2_klen_out",      128'(klen_out), 128'(2));
        push_rev(2, 15, 14, 16);
        for (int i = 0; i < 15; i++) begin
            ek_vld = 1'b0;
            tick();
            chk("t2_ek_rdy_gap", 128'(ek_rdy),   128'(1));
            chk("t2_vld_gap",    128'(rkey_vld), 128'(0));
            ek_vld = 1'b1;
            ek     = mk(2, i);
            tick();
        end
        ek_vld = 1'b0;
        chk("t2_rkey_vld_rise", 128'(rkey_vld), 128'(1));
        chk("t2_ek_rdy_ready",  128'(ek_rdy),   128'(0));
        chk("t2_first_rkey",    rkey,           mk(2, 14));
        next_rkey = 1'b1;
        repeat (16) tick();
        next_rkey = 1'b0;
        chk("t2_after_wrap", rkey, mk(2, 13));
        push_rev(2, 15, 13, 14);
        next_rkey = 1'b1;
        repeat (14) tick();
        next_rkey = 1'b0;
        chk("t2_boundary", rkey, mk(2, 14));

        // Deferred reload: 192-bit schedule, new 128-bit key mid-block.
        new_key = 1'b1; klen_sel = 2'b01;
        tick();
        new_key = 1'b0;
        chk("t3_klen_out_192", 128'(klen_out), 128'(1));
        load(3, 13);
        chk("t3_first_rkey", rkey, mk(3, 12));
        push_rev(3, 13, 12, 13);
        next_rkey = 1'b1;
        repeat (5) tick();
        new_key = 1'b1; klen_sel = 2'b00;
        tick();
        new_key = 1'b0; klen_sel = 2'b11;
        chk("t3_load_pend",   128'(load_pend), 128'(1));
        chk("t3_still_vld",   128'(rkey_vld),  128'(1));
        chk("t3_klen_kept",   128'(klen_out),  128'(1));
        chk("t3_rkey_serve",  rkey,            mk(3, 6));
        repeat (7) tick();
        next_rkey = 1'b0;
        chk("t3_wrap_vld",    128'(rkey_vld),  128'(0));
        chk("t3_wrap_ek_rdy", 128'(ek_rdy),    128'(1));
        chk("t3_pend_clr",    128'(load_pend), 128'(0));
        chk("t3_klen_new",    128'(klen_out),  128'(0));
        load(4, 11);
        chk("t3_reload_vld", 128'(rkey_vld), 128'(1));
        push_rev(4, 11, 10, 11);
        next_rkey = 1'b1;
        repeat (11) tick();
        next_rkey = 1'b0;

        // Reset after 6 of 11 transfers.
        new_key = 1'b1; klen_sel = 2'b00;
        tick();
        new_key = 1'b0;
        load(5, 6);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ek_rdy",   128'(ek_rdy),   128'(0));
        chk("t5_rkey_vld", 128'(rkey_vld), 128'(0));
        chk("t5_klen_out", 128'(klen_out), 128'(0));

        // Invalid length in EMPTY, then recovery with a full 256-bit load.
        new_key = 1'b1; klen_sel = 2'b11;
        tick();
        new_key = 1'b0;
        chk("t4_klen_err", 128'(klen_err), 128'(1));
        chk("t4_ek_rdy",   128'(ek_rdy),   128'(0));
        tick();
        chk("t4_ek_rdy_hold", 128'(ek_rdy), 128'(0));
        new_key = 1'b1; klen_sel = 2'b10;
        tick();
        new_key = 1'b0;
        chk("t4_err_clr",  128'(klen_err), 128'(0));
        chk("t4_ek_rdy_1", 128'(ek_rdy),   128'(1));
        load(6, 15);
        chk("t4_first_rkey", rkey, mk(6, 14));
        push_rev(6, 15, 14, 15);
        next_rkey = 1'b1;
        repeat (3) tick();
        new_key = 1'b1; klen_sel = 2'b11;
        tick();
        new_key = 1'b0;
        chk("t4_pend_inv",     128'(load_pend), 128'(1));
        chk("t4_err_deferred", 128'(klen_err),  128'(0));
        repeat (11) tick();
        next_rkey = 1'b0;
        chk("t4_wrap_err",    128'(klen_err),  128'(1));
        chk("t4_wrap_vld",    128'(rkey_vld),  128'(0));
        chk("t4_wrap_ek_rdy", 128'(ek_rdy),    128'(0));
        chk("t4_wrap_pend",   128'(load_pend), 128'(0));
        chk("t4_klen_kept",   128'(klen_out),  128'(2));

        tick();
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rkey_rev_buf.md
Name: rkey_rev_buf

Overview:
- Round-key reversal buffer. Sits directly upstream of the AES decryption engine's rkey/rkey_vld/next_rkey port.
- Accepts round keys from the forward key expander in encryption order rk[0]..rk[Nr] and stores them.
- Replays them in inverse-cipher order rk[Nr]..rk[0], one per next_rkey. Repeats the sequence for every ciphertext block until a new key is loaded.

Parameters:
- KW, 128, round-key width in bits.
- NUM_RK_MAX, 15, storage depth (Nr+1 for AES-256).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- new_key  in  1  pulse: request a new schedule load; klen_sel sampled on the same cycle.
- klen_sel  in  2  00=128, 01=192, 10=256, 11=invalid.
- ek  in  KW  forward-order round key from the expander.
- ek_vld  in  1  ek valid.
- ek_rdy  out  1  buffer accepts ek; transfer when ek_vld & ek_rdy.
- rkey  out  KW  round key to the decrypt engine.
- rkey_vld  out  1  full schedule present.
- next_rkey  in  1  decrypt engine consumes the current rkey.
- klen_out  out  2  latched key length of the stored schedule; drives the decrypt engine's klen_sel.
- klen_err  out  1  sticky: last new_key carried klen_sel=11.
- load_pend  out  1  new_key accepted but deferred until the block boundary.

Behaviour:
- Nkeys = Nr+1 = 11/13/15 for klen 00/01/10.
- Storage: NUM_RK_MAX x KW register array. rkey = mem[rd_ptr] is combinational from the registered rd_ptr.
- Reset values: state=EMPTY, ek_rdy=0, rkey_vld=0, klen_out=00, klen_err=0, load_pend=0, wr_cnt=0, rd_ptr=0. rkey is don't-care and is driven from mem[0]. Memory is not cleared.
- EMPTY:
  - new_key & klen_sel!=11 -> LOAD: latch klen_out, wr_cnt=0, clear klen_err.
  - new_key & klen_sel==11 -> stay EMPTY, klen_err=1.
- LOAD:
  - ek_rdy=1, rkey_vld=0.
  - Each ek transfer writes mem[wr_cnt], then wr_cnt++.
  - The transfer with wr_cnt==Nkeys-1 -> READY next cycle, with rd_ptr=Nkeys-1.
  - Gaps in ek_vld only stall.
  - new_key in LOAD restarts the load: wr_cnt=0, relatch klen (or raise klen_err and go to EMPTY if 11).
  - next_rkey is ignored.
- READY:
  - rkey_vld=1, ek_rdy=0.
  - next_rkey: rd_ptr = (rd_ptr==0) ? Nkeys-1 : rd_ptr-1.
  - Latency: rkey_vld rises the cycle after the last ek transfer. The first rkey is rk[Nr].
- Block boundary: rd_ptr==Nkeys-1.
  - new_key at the boundary with no next_rkey that cycle -> LOAD next cycle, rkey_vld=0.
  - new_key mid-block (rd_ptr!=Nkeys-1, or next_rkey the same cycle) -> set load_pend and latch the pending klen_sel. Keep serving.
  - When rd_ptr wraps to Nkeys-1 -> LOAD using the pending klen, then clear load_pend.
  - A later new_key while pending overwrites the pending klen.
  - Pending klen=11 -> klen_err=1, go to EMPTY instead of LOAD.
- klen_sel changes outside new_key have no effect.
- rst mid-operation: immediate return to reset values. The partial schedule is discarded; rkey_vld=0 the next cycle.
- next_rkey while rkey_vld=0 is ignored (no pointer movement).

Decomposition:
- Package aes_dec_pkg:
  - klen_t enum (K128, K192, K256, KINV).
  - function nkeys(klen_t) returning 11/13/15.
  - localparam NUM_RK_MAX=15, localparam KW=128.
  - rkbuf_state_t enum (EMPTY, LOAD, READY).
- One natural sub-module, rk_store: synchronous-write / async-read register array. It also allows a distributed-RAM mapping. The FSM and pointers stay in the top.

Test Plan:
- 128-bit load: new_key with klen=00, then ek=128'h{i} for i=0..10 back-to-back. Then next_rkey held high for 22 cycles -> rkey_vld rises 1 cycle after i=10; rkey sequence 10,9,...,0,10,...,0; klen_out=00.
- 256-bit load with ek_vld toggling every other cycle -> ek_rdy=1 throughout LOAD, exactly 15 writes, rkey_vld rises after the 15th. First rkey=14, after 14 pops rkey=0, then wraps to 14.
- Deferred reload: READY (klen=01), pop 5 keys, pulse new_key with klen=00 -> load_pend=1, rkey continues 7..0. At the wrap, rkey_vld=0 and ek_rdy=1; after 11 transfers, READY with klen_out=00.
- Invalid length: new_key with klen=11 in EMPTY -> klen_err=1, ek_rdy stays 0. A following new_key with klen=10 clears klen_err.
- Reset mid-load: rst asserted after 6 of 11 transfers -> the next cycle has ek_rdy=0, rkey_vld=0, klen_out=00. A fresh full load works correctly.
- Stray next_rkey in EMPTY/LOAD -> no effect; the first rkey after READY is still rk[Nr].
